// File: rtl/hazard_pkg.sv
// Shared constants and slot-entry layout for the hazard scoreboard.
// The register-address half of a slot entry is added per instance because AW is a parameter.
package hazard_pkg;
  localparam int HZ_AW        = 5;
  localparam int HZ_DEPTH     = 3;
  localparam int HZ_LOAD_SLOT = 2;
  localparam int HZ_BR_SLOT   = 1;
  localparam int HZ_MUL_LAT   = 4;

  localparam int FWD_REGFILE  = 0;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic hilo;
  } slot_flags_t;

  localparam int SLOT_FLAG_W = $bits(slot_flags_t);

  function automatic int slot_w(input int aw);
    return aw + SLOT_FLAG_W;
  endfunction
endpackage

// File: rtl/hazard_slot_pipe.sv
// DEPTH-entry in-flight tracker: shifts every cycle, kill_i[i] squashes the entry leaving slot i.
// An all-zero entry is a bubble, so killing simply clears the word.
module hazard_slot_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 9
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [W-1:0]            entry_i,
  input  logic [DEPTH-2:0]        kill_i,
  output logic [DEPTH-1:0][W-1:0] slot_o
);
  logic [DEPTH-1:0][W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d    = '0;
    slot_d[0] = entry_i;
    for (int i = 1; i < DEPTH; i++)
      slot_d[i] = kill_i[i-1] ? '0 : slot_q[i-1];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign slot_o = slot_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight producers from EX to WB and derives
// load-use and HI/LO stalls, branch flushes, registered EX forward selects and WB->ID bypass.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int  AW        = HZ_AW,
  parameter int  DEPTH     = HZ_DEPTH,
  parameter int  LOAD_SLOT = HZ_LOAD_SLOT,
  parameter int  BR_SLOT   = HZ_BR_SLOT,
  parameter int  MUL_LAT   = HZ_MUL_LAT,
  localparam int SW        = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          IdValid,
  input  logic [AW-1:0] IdRs,
  input  logic [AW-1:0] IdRt,
  input  logic          IdUsesRs,
  input  logic          IdUsesRt,
  input  logic [AW-1:0] IdRd,
  input  logic          IdRegWrite,
  input  logic          IdMemRead,
  input  logic          IdHiLoStart,
  input  logic          IdHiLoRead,
  input  logic          BranchTaken,
  output logic          Stall,
  output logic          FlushIfId,
  output logic          FlushIdEx,
  output logic [SW-1:0] FwdSelA,
  output logic [SW-1:0] FwdSelB,
  output logic          IdBypassA,
  output logic          IdBypassB,
  output logic          HiLoBusy
);
  typedef struct packed {
    slot_flags_t   f;
    logic [AW-1:0] rd;
  } slot_t;

  localparam int W  = slot_w(AW);
  localparam int CW = $clog2(MUL_LAT + 1);

  slot_t [DEPTH-1:0] slot;
  slot_t             entry;
  logic [DEPTH-2:0]  kill;
  logic              kill_mult;

  logic [1:0][AW-1:0] src;
  logic [1:0]         use_src, hit, hit_ld, lu, byp;
  logic [1:0][SW-1:0] hidx, fwd_nxt;

  logic          stall_int, hilo_stall, issue;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  hazard_slot_pipe #(.DEPTH(DEPTH), .W(W)) u_pipe (
    .Clk     (Clk),
    .Reset   (Reset),
    .entry_i (entry),
    .kill_i  (kill),
    .slot_o  (slot)
  );

  assign src     = {IdRt, IdRs};
  assign use_src = {IdUsesRt, IdUsesRs};

  always_comb begin
    hit     = '0;
    hit_ld  = '0;
    hidx    = '0;
    lu      = '0;
    byp     = '0;
    fwd_nxt = '0;
    for (int s = 0; s < 2; s++) begin
      // Scan oldest to youngest so the youngest producer is the one left standing.
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (IdValid && use_src[s] && (src[s] != '0) && slot[i].f.valid &&
            slot[i].f.regwrite && (slot[i].rd == src[s])) begin
          hit[s]    = 1'b1;
          hit_ld[s] = slot[i].f.memread;
          hidx[s]   = SW'(i);
        end
      end
      byp[s]     = hit[s] && (hidx[s] == SW'(DEPTH-1));
      fwd_nxt[s] = (hit[s] && !byp[s]) ? hidx[s] + SW'(1) : SW'(FWD_REGFILE);
      lu[s]      = hit_ld[s] && ((int'(hidx[s]) + 1) < LOAD_SLOT);
    end
  end

  assign hilo_stall = (cnt_q != '0) && IdValid && (IdHiLoStart || IdHiLoRead);
  assign stall_int  = IdValid && !BranchTaken && ((|lu) || hilo_stall);
  assign issue      = IdValid && !stall_int && !BranchTaken;

  // Instructions younger than the resolving branch sit in slots below BR_SLOT.
  always_comb begin
    kill      = '0;
    kill_mult = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (BranchTaken && (i < BR_SLOT)) begin
        if (i < DEPTH-1) kill[i] = 1'b1;
        kill_mult = kill_mult | (slot[i].f.valid && slot[i].f.hilo);
      end
    end
  end

  always_comb begin
    entry = '0;
    if (issue) begin
      entry.f.valid    = 1'b1;
      entry.f.regwrite = IdRegWrite;
      entry.f.memread  = IdMemRead;
      entry.f.hilo     = IdHiLoStart;
      entry.rd         = IdRd;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (BranchTaken && kill_mult)  cnt_d = '0;
    else if (issue && IdHiLoStart) cnt_d = CW'(MUL_LAT);
    else if (cnt_q != '0)          cnt_d = cnt_q - CW'(1);
  end

  // During a stall EX holds a bubble, so the selects are left alone.
  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!stall_int) begin
      fwd_a_d = issue ? fwd_nxt[0] : SW'(FWD_REGFILE);
      fwd_b_d = issue ? fwd_nxt[1] : SW'(FWD_REGFILE);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q   <= '0;
      fwd_a_q <= SW'(FWD_REGFILE);
      fwd_b_q <= SW'(FWD_REGFILE);
    end else begin
      cnt_q   <= cnt_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign Stall     = stall_int;
  assign FlushIfId = BranchTaken && !Reset;
  assign FlushIdEx = BranchTaken && !Reset;
  assign FwdSelA   = fwd_a_q;
  assign FwdSelB   = fwd_b_q;
  assign IdBypassA = byp[0];
  assign IdBypassB = byp[1];
  assign HiLoBusy  = (cnt_q != '0);
endmodule
